mem_hit_arbiter: RTL and testbench

Memory-side counterpart to the pipeline hazard logic: arbitrates the fetch-stage instruction request and the mem-stage data request onto the single-ported RAM. Generates the ihit/dhit pulses and load data that the hazard logic uses to stall or advance pipeline latches. Sits between the pipeline datapath and the RAM controller.

---
 rtl/mem_hit_arbiter_if.sv | 46 ++++
 rtl/mem_hit_arbiter.sv | 133 +++++++++++++
 tb/tb_mem_hit_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_hit_arbiter_if.sv
// Pipeline-side and RAM-side signals of mem_hit_arbiter.
// Defining MEM_PERF_CNT_EN adds the istall_cnt/dstall_cnt stall counters.
interface mem_hit_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic              ihit;
    logic              dhit;
    logic [DATA_W-1:0] iload;
    logic [DATA_W-1:0] dload;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic [1:0]        ramstate;
    logic              memerr;
`ifdef MEM_PERF_CNT_EN
    logic [31:0]       istall_cnt;
    logic [31:0]       dstall_cnt;
`endif

    // Arbiter's view.
    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef MEM_PERF_CNT_EN
        , output istall_cnt, dstall_cnt
`endif
    );

    // Pipeline and RAM controller's view.
    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, memerr
`ifdef MEM_PERF_CNT_EN
        , input istall_cnt, dstall_cnt
`endif
    );
endinterface

// File: rtl/mem_hit_arbiter.sv
// Arbitrates fetch and mem-stage requests onto a single-ported RAM, producing ihit/dhit pulses.
// Optional MEM_PERF_CNT_EN adds saturating instruction/data stall counters.
module mem_hit_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RST,
    mem_hit_arbiter_if.slave  bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RAM_FREE   = 2'd0,
        RAM_BUSY   = 2'd1,
        RAM_ACCESS = 2'd2,
        RAM_ERROR  = 2'd3
    } ram_state_t;

    typedef enum logic [1:0] {IDLE, IACC, DACC, ERR} state_t;

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          access;
    logic          ram_fault;

    assign access    = (bus.ramstate == RAM_ACCESS);
    assign ram_fault = (bus.ramstate == RAM_ERROR);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            tcnt         <= '0;
            bus.ihit     <= 1'b0;
            bus.dhit     <= 1'b0;
            bus.iload    <= {DATA_W{1'b0}};
            bus.dload    <= {DATA_W{1'b0}};
            bus.ramREN   <= 1'b0;
            bus.ramWEN   <= 1'b0;
            bus.ramaddr  <= {ADDR_W{1'b0}};
            bus.ramstore <= {DATA_W{1'b0}};
            bus.memerr   <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the hits single-cycle pulses; a later
            // assignment in the same block overrides them for the completing cycle.
            bus.ihit <= 1'b0;
            bus.dhit <= 1'b0;

            case (state)
                IDLE: begin
                    // The cycle carrying a hit is a turnaround: the request that just
                    // completed may still be asserted and must not be re-serviced.
                    if (!(bus.ihit || bus.dhit)) begin
                        if (bus.dREN || bus.dWEN) begin
                            state        <= DACC;
                            tcnt         <= '0;
                            bus.ramWEN   <= bus.dWEN;
                            bus.ramREN   <= bus.dREN & ~bus.dWEN;
                            bus.ramaddr  <= bus.daddr;
                            bus.ramstore <= bus.dstore;
                        end else if (bus.iREN) begin
                            state        <= IACC;
                            tcnt         <= '0;
                            bus.ramREN   <= 1'b1;
                            bus.ramWEN   <= 1'b0;
                            bus.ramaddr  <= bus.iaddr;
                        end
                    end
                end

                IACC: begin
                    if (access) begin
                        bus.iload  <= bus.ramload;
                        bus.ihit   <= 1'b1;
                        bus.ramREN <= 1'b0;
                        state      <= IDLE;
                    end else if (ram_fault || tcnt == TCNT_LAST) begin
                        bus.ramREN <= 1'b0;
                        bus.memerr <= 1'b1;
                        state      <= ERR;
                    end else if (!bus.iREN) begin
                        bus.ramREN <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                DACC: begin
                    // Strobes stay as latched on entry; data accesses are never aborted.
                    if (access) begin
                        if (bus.ramREN) bus.dload <= bus.ramload;
                        bus.dhit   <= 1'b1;
                        bus.ramREN <= 1'b0;
                        bus.ramWEN <= 1'b0;
                        state      <= IDLE;
                    end else if (ram_fault || tcnt == TCNT_LAST) begin
                        bus.ramREN <= 1'b0;
                        bus.ramWEN <= 1'b0;
                        bus.memerr <= 1'b1;
                        state      <= ERR;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                ERR: begin
                    bus.ramREN <= 1'b0;
                    bus.ramWEN <= 1'b0;
                    bus.memerr <= 1'b1;
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_PERF_CNT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.istall_cnt <= '0;
            bus.dstall_cnt <= '0;
        end else begin
            if (bus.iREN && !bus.ihit && bus.istall_cnt != '1)
                bus.istall_cnt <= bus.istall_cnt + 1'b1;
            if ((bus.dREN || bus.dWEN) && !bus.dhit && bus.dstall_cnt != '1)
                bus.dstall_cnt <= bus.dstall_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_hit_arbiter.sv
// Directed bench for mem_hit_arbiter: expected hits are queued when requests are driven
// and popped when ihit/dhit appear; RAM responses are driven step by step.
module tb_mem_hit_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_hit_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_hit_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic        is_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_hit(input string tag);
        exp_t e;
        check({tag, "_pending"}, 64'(sb.size() == 0), 64'd0);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check({tag, "_ihit"}, 64'(bus.ihit), 64'(!e.is_data));
        check({tag, "_dhit"}, 64'(bus.dhit), 64'(e.is_data));
        if (e.is_data) check({tag, "_dload"}, 64'(bus.dload), 64'(e.data));
        else           check({tag, "_iload"}, 64'(bus.iload), 64'(e.data));
    endtask

    // Strobes and hits must be mutually exclusive in every cycle.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("excl_strobe", 64'(bus.ramREN & bus.ramWEN), 64'd0);
            check("excl_hit", 64'(bus.ihit & bus.dhit), 64'd0);
        end
    end

    initial begin
        bus.iREN = 1'b0; bus.iaddr = '0;
        bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
        bus.ramload = '0; bus.ramstate = FREE;

        // Reset state.
        tick(); tick();
        check("rst_ramREN", 64'(bus.ramREN), 64'd0);
        check("rst_ramWEN", 64'(bus.ramWEN), 64'd0);
        check("rst_hits", 64'({bus.ihit, bus.dhit}), 64'd0);
        check("rst_memerr", 64'(bus.memerr), 64'd0);
        check("rst_loads", 64'({bus.iload, bus.dload}), 64'd0);
        rst = 1'b0;
        tick();

        // Fetch with ACCESS two cycles after the strobe.
        bus.iREN = 1'b1; bus.iaddr = 32'h40;
        sb.push_back('{1'b0, 32'h8C22_0004});
        tick();
        check("f_ramREN_c1", 64'(bus.ramREN), 64'd1);
        check("f_ramaddr", 64'(bus.ramaddr), 64'h40);
        bus.ramstate = BUSY;
        tick();
        check("f_ramREN_c2", 64'(bus.ramREN), 64'd1);
        check("f_ihit_c2", 64'(bus.ihit), 64'd0);
        bus.ramstate = ACCESS; bus.ramload = 32'h8C22_0004;
        tick();
        check_hit("fetch");
        check("f_no_reissue_c3", 64'(bus.ramREN), 64'd0);
        bus.ramstate = FREE; bus.ramload = '0;
        tick();
        check("f_turnaround_ramREN", 64'(bus.ramREN), 64'd0);
        check("f_ihit_pulse", 64'(bus.ihit), 64'd0);
        bus.iREN = 1'b0;
        tick();

        // Contention: data first, turnaround, then instruction.
        bus.iREN = 1'b1; bus.iaddr = 32'h44;
        bus.dREN = 1'b1; bus.daddr = 32'h100;
        sb.push_back('{1'b1, 32'h1111_2222});
        sb.push_back('{1'b0, 32'hAAAA_0001});
        tick();
        check("c_dacc_ramREN", 64'(bus.ramREN), 64'd1);
        check("c_dacc_ramaddr", 64'(bus.ramaddr), 64'h100);
        bus.ramstate = ACCESS; bus.ramload = 32'h1111_2222;
        tick();
        check_hit("cont_data");
        bus.ramstate = FREE;
        tick();
        check("c_turnaround", 64'(bus.ramREN), 64'd0);
        bus.dREN = 1'b0;
        tick();
        check("c_iacc_ramREN", 64'(bus.ramREN), 64'd1);
        check("c_iacc_ramaddr", 64'(bus.ramaddr), 64'h44);
        bus.ramstate = ACCESS; bus.ramload = 32'hAAAA_0001;
        tick();
        check_hit("cont_inst");
        bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();

        // Write: dload must keep the last read value.
        bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
        sb.push_back('{1'b1, 32'h1111_2222});
        tick();
        check("w_ramWEN", 64'(bus.ramWEN), 64'd1);
        check("w_ramREN", 64'(bus.ramREN), 64'd0);
        check("w_ramstore", 64'(bus.ramstore), 64'hDEAD_BEEF);
        check("w_ramaddr", 64'(bus.ramaddr), 64'h200);
        bus.ramstate = BUSY;
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h5555_5555;
        tick();
        check_hit("write");
        bus.dWEN = 1'b0; bus.ramstate = FREE;
        tick();
        check("w_dhit_pulse", 64'(bus.dhit), 64'd0);

        // Flush in IACC, then a normal fetch to 0x80.
        bus.iREN = 1'b1; bus.iaddr = 32'h60;
        tick();
        check("fl_ramREN", 64'(bus.ramREN), 64'd1);
        bus.ramstate = BUSY; bus.iREN = 1'b0;
        tick();
        check("fl_abort_ramREN", 64'(bus.ramREN), 64'd0);
        check("fl_abort_ihit", 64'(bus.ihit), 64'd0);
        bus.ramstate = FREE;
        tick();
        check("fl_no_ihit", 64'(bus.ihit), 64'd0);
        check("fl_iload_kept", 64'(bus.iload), 64'hAAAA_0001);
        bus.iREN = 1'b1; bus.iaddr = 32'h80;
        sb.push_back('{1'b0, 32'h1234_0080});
        tick();
        check("fl2_ramREN", 64'(bus.ramREN), 64'd1);
        check("fl2_ramaddr", 64'(bus.ramaddr), 64'h80);
        bus.ramstate = ACCESS; bus.ramload = 32'h1234_0080;
        tick();
        check_hit("after_flush");
        bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();

        // Reset in the middle of a data access.
        bus.dREN = 1'b1; bus.daddr = 32'h300;
        tick();
        check("r_dacc_ramREN", 64'(bus.ramREN), 64'd1);
        bus.ramstate = BUSY; rst = 1'b1;
        tick();
        check("r_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check("r_addr_store", 64'({bus.ramaddr, bus.ramstore}), 64'd0);
        check("r_hits_err", 64'({bus.ihit, bus.dhit, bus.memerr}), 64'd0);
        check("r_loads", 64'({bus.iload, bus.dload}), 64'd0);
        rst = 1'b0; bus.dREN = 1'b0; bus.ramstate = ACCESS; bus.ramload = 32'h99;
        tick();
        check("r_no_dhit_1", 64'(bus.dhit), 64'd0);
        check("r_idle_ramREN", 64'(bus.ramREN), 64'd0);
        bus.ramstate = FREE;
        tick();
        check("r_no_dhit_2", 64'(bus.dhit), 64'd0);

        // RAM ERROR during DACC: sticky until reset.
        bus.dREN = 1'b1; bus.daddr = 32'h400;
        tick();
        check("e_ramREN", 64'(bus.ramREN), 64'd1);
        bus.ramstate = ERROR;
        tick();
        check("e_memerr", 64'(bus.memerr), 64'd1);
        check("e_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check("e_dhit", 64'(bus.dhit), 64'd0);
        bus.ramstate = ACCESS; bus.ramload = 32'h77; bus.iREN = 1'b1; bus.iaddr = 32'h10;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("e_sticky_memerr", 64'(bus.memerr), 64'd1);
            check("e_sticky_hits", 64'({bus.ihit, bus.dhit}), 64'd0);
            check("e_sticky_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        end
        rst = 1'b1; bus.dREN = 1'b0; bus.iREN = 1'b0; bus.ramstate = FREE;
        tick();
        check("e_rst_memerr", 64'(bus.memerr), 64'd0);
        rst = 1'b0;
        tick();

        // Timeout: RAM held BUSY for TIMEOUT access cycles.
        bus.iREN = 1'b1; bus.iaddr = 32'h500; bus.ramstate = BUSY;
        for (int k = 1; k <= TO; k++) begin
            tick();
            check("t_memerr_low", 64'(bus.memerr), 64'd0);
            check("t_ramREN", 64'(bus.ramREN), 64'd1);
        end
        tick();
        check("t_memerr", 64'(bus.memerr), 64'd1);
        check("t_strobes", 64'({bus.ramREN, bus.ramWEN}), 64'd0);
        check("t_ihit", 64'(bus.ihit), 64'd0);
        bus.iREN = 1'b0; bus.ramstate = FREE;

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
